rv_id_r: RTL and testbench

- R-type decode/operand-fetch stage directly upstream of rv_alu_r.
- Accepts 32-bit instructions over a valid/ready handshake and decodes the R-type fields.
- Reads rs1/rs2 from an internal 32x32 register file that also takes the writeback port.
- Presents registered operands plus funct3/funct7_r to the ALU through a one-entry output pipeline register with valid/ready.

---
 rtl/rv_pkg.sv | 31 +++
 rtl/rv_regfile.sv | 42 ++++
 rtl/rv_id_r.sv | 128 ++++++++++++
 tb/tb_rv_id_r.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared R-type decode constants, register index type and the legality rule
// used by the decode stage.
package rv_pkg;

  localparam logic [6:0] OPCODE_OP   = 7'b0110011;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // funct3 encodings shared with rv_alu_r; ADD/SUB and SRL/SRA differ only in funct7.
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef logic [4:0] reg_idx_t;

  function automatic logic is_legal_r(input logic [31:0] instr);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = instr[31:25];
    f3 = instr[14:12];
    return (instr[6:0] == OPCODE_OP) &&
           ((f7 == FUNCT7_BASE) ||
            ((f7 == FUNCT7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRL))));
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// Architectural register file: two async read ports with write-through bypass,
// one synchronous write port, x0 hardwired to zero.
module rv_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned IW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   rs1_idx_i,
  input  logic [IW-1:0]   rs2_idx_i,
  output logic [XLEN-1:0] rs1_dat_o,
  output logic [XLEN-1:0] rs2_dat_o,
  input  logic            wb_en_i,
  input  logic [IW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_dat_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_en_i && (wb_rd_i != '0)) begin
      regs_q[wb_rd_i] <= wb_dat_i;
    end
  end

  // Same-cycle writeback wins over the stored value so the reader sees the new data.
  always_comb begin
    rs1_dat_o = regs_q[rs1_idx_i];
    if (rs1_idx_i == '0) rs1_dat_o = '0;
    else if (wb_en_i && (wb_rd_i == rs1_idx_i)) rs1_dat_o = wb_dat_i;
  end

  always_comb begin
    rs2_dat_o = regs_q[rs2_idx_i];
    if (rs2_idx_i == '0) rs2_dat_o = '0;
    else if (wb_en_i && (wb_rd_i == rs2_idx_i)) rs2_dat_o = wb_dat_i;
  end

endmodule

// File: rtl/rv_id_r.sv
// R-type decode/operand-fetch stage feeding rv_alu_r through a one-entry output register.
// Define RV_ID_SCOREBOARD_EN to add a pending-write mask that stalls on RAW hazards.
module rv_id_r #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_in,
  input  logic            instr_valid_in,
  output logic            instr_ready_out,
  input  logic            wb_en_in,
  input  logic [4:0]      wb_rd_in,
  input  logic [XLEN-1:0] wb_data_in,
  output logic [XLEN-1:0] rs1_out,
  output logic [XLEN-1:0] rs2_out,
  output logic [2:0]      funct3_out,
  output logic            funct7_r_out,
  output logic [4:0]      rd_out,
  output logic            ex_valid_out,
  input  logic            ex_ready_in,
  output logic            illegal_out
);
  import rv_pkg::*;

  reg_idx_t        rs1_idx, rs2_idx, rd_idx;
  logic [2:0]      f3;
  logic            legal, accept, hazard;
  logic [XLEN-1:0] rs1_dat, rs2_dat;

  logic            ex_valid_q, ex_valid_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]      f3_q, f3_d;
  logic            f7r_q, f7r_d;
  reg_idx_t        rd_q, rd_d;

  assign rd_idx  = instr_in[11:7];
  assign f3      = instr_in[14:12];
  assign rs1_idx = instr_in[19:15];
  assign rs2_idx = instr_in[24:20];
  assign legal   = is_legal_r(instr_in);

  rv_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rs1_idx_i (rs1_idx),
    .rs2_idx_i (rs2_idx),
    .rs1_dat_o (rs1_dat),
    .rs2_dat_o (rs2_dat),
    .wb_en_i   (wb_en_in),
    .wb_rd_i   (wb_rd_in),
    .wb_dat_i  (wb_data_in)
  );

`ifdef RV_ID_SCOREBOARD_EN
  logic [31:0] pend_q, pend_d, wb_clr;

  // A writeback landing this cycle resolves the hazard; the bypass supplies the value.
  always_comb begin
    wb_clr = wb_en_in ? (32'd1 << wb_rd_in) : 32'd0;
    hazard = instr_valid_in &&
             ((pend_q[rs1_idx] && !wb_clr[rs1_idx]) ||
              (pend_q[rs2_idx] && !wb_clr[rs2_idx]));
    pend_d = pend_q & ~wb_clr;
    if (accept && legal && (rd_idx != '0)) pend_d[rd_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end
`else
  assign hazard = 1'b0;
`endif

  assign instr_ready_out = (!ex_valid_q || ex_ready_in) && !hazard;
  assign accept          = instr_valid_in && instr_ready_out;

  always_comb begin
    ex_valid_d = ex_valid_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    f3_d       = f3_q;
    f7r_d      = f7r_q;
    rd_d       = rd_q;
    illegal_d  = accept && !legal;
    if (accept && legal) begin
      ex_valid_d = 1'b1;
      rs1_d      = rs1_dat;
      rs2_d      = rs2_dat;
      f3_d       = f3;
      f7r_d      = instr_in[30];
      rd_d       = rd_idx;
    end else if (ex_ready_in) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      f3_q       <= '0;
      f7r_q      <= 1'b0;
      rd_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      illegal_q  <= illegal_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      f3_q       <= f3_d;
      f7r_q      <= f7r_d;
      rd_q       <= rd_d;
    end
  end

  assign ex_valid_out = ex_valid_q;
  assign illegal_out  = illegal_q;
  assign rs1_out      = rs1_q;
  assign rs2_out      = rs2_q;
  assign funct3_out   = f3_q;
  assign funct7_r_out = f7r_q;
  assign rd_out       = rd_q;

endmodule

// File: tb/tb_rv_id_r.sv
// Bench for rv_id_r: directed vector table, hand sequences and a randomized run,
// all checked against a register-array reference model.
module tb_rv_id_r;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic        instr_valid_in;
  logic        instr_ready_out;
  logic        wb_en_in;
  logic [4:0]  wb_rd_in;
  logic [31:0] wb_data_in;
  logic [31:0] rs1_out, rs2_out;
  logic [2:0]  funct3_out;
  logic        funct7_r_out;
  logic [4:0]  rd_out;
  logic        ex_valid_out;
  logic        ex_ready_in;
  logic        illegal_out;

  rv_id_r dut (
    .clk             (clk),
    .rst             (rst),
    .instr_in        (instr_in),
    .instr_valid_in  (instr_valid_in),
    .instr_ready_out (instr_ready_out),
    .wb_en_in        (wb_en_in),
    .wb_rd_in        (wb_rd_in),
    .wb_data_in      (wb_data_in),
    .rs1_out         (rs1_out),
    .rs2_out         (rs2_out),
    .funct3_out      (funct3_out),
    .funct7_r_out    (funct7_r_out),
    .rd_out          (rd_out),
    .ex_valid_out    (ex_valid_out),
    .ex_ready_in     (ex_ready_in),
    .illegal_out     (illegal_out)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: architectural registers, pending writers, and the ALU-facing slot.
  logic [31:0] m_rf [32];
  logic        m_pend [32];
  logic        m_ev, m_ill, m_f7;
  logic [31:0] m_rs1, m_rs2;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  logic        last_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Legal set: opcode OP with any funct3 under base funct7, or SUB/SRA under alt funct7.
  function automatic logic legal_r(input logic [31:0] ins);
    logic [9:0] key;
    logic       ok;
    key = {ins[31:25], ins[14:12]};
    ok  = 1'b0;
    for (int i = 0; i < 8; i++) if (key == {7'h00, i[2:0]}) ok = 1'b1;
    if (key == {7'h20, 3'd0} || key == {7'h20, 3'd5}) ok = 1'b1;
    return ok && (ins[6:0] == 7'h33);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx, input logic we,
                                         input logic [4:0] wr, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (we && wr == idx) return wd;
    return m_rf[idx];
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [31:0] ins, input logic we,
                     input logic [4:0] wr, input logic [31:0] wd, input logic rdy);
    logic [4:0] a, b;
    logic       hz, mr, acc, lg;
    rst = r; instr_valid_in = v; instr_in = ins;
    wb_en_in = we; wb_rd_in = wr; wb_data_in = wd; ex_ready_in = rdy;
    a  = ins[19:15];
    b  = ins[24:20];
    hz = 1'b0;
`ifdef RV_ID_SCOREBOARD_EN
    hz = v && ((m_pend[a] && !(we && wr == a)) || (m_pend[b] && !(we && wr == b)));
`endif
    mr = (!m_ev || rdy) && !hz;
    #1;
    last_rdy = instr_ready_out;
    if (!r) chk("instr_ready_out", {31'd0, instr_ready_out}, {31'd0, mr});
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin m_rf[i] = 32'd0; m_pend[i] = 1'b0; end
      m_ev = 0; m_ill = 0; m_rs1 = 0; m_rs2 = 0; m_f3 = 0; m_f7 = 0; m_rd = 0;
    end else begin
      acc = v && mr;
      lg  = legal_r(ins);
      if (acc && lg) begin
        m_ev  = 1'b1;
        m_rs1 = m_read(a, we, wr, wd);
        m_rs2 = m_read(b, we, wr, wd);
        m_f3  = ins[14:12];
        m_f7  = ins[30];
        m_rd  = ins[11:7];
      end else if (rdy) begin
        m_ev = 1'b0;
      end
      m_ill = acc && !lg;
      if (we) m_pend[wr] = 1'b0;
      if (acc && lg && ins[11:7] != 5'd0) m_pend[ins[11:7]] = 1'b1;
      if (we && wr != 5'd0) m_rf[wr] = wd;
    end
    #1;
    chk("ex_valid_out", {31'd0, ex_valid_out}, {31'd0, m_ev});
    chk("illegal_out",  {31'd0, illegal_out},  {31'd0, m_ill});
    chk("rs1_out", rs1_out, m_rs1);
    chk("rs2_out", rs2_out, m_rs2);
    chk("funct3_out",   {29'd0, funct3_out},   {29'd0, m_f3});
    chk("funct7_r_out", {31'd0, funct7_r_out}, {31'd0, m_f7});
    chk("rd_out",       {27'd0, rd_out},       {27'd0, m_rd});
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] ins;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        rdy;
    logic        ev;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t tbl [10];

  localparam logic [31:0] OP_A = 32'h0053_64B3;  // OR  x9,x6,x5
  localparam logic [31:0] OP_B = 32'h0063_0533;  // ADD x10,x6,x6

  initial begin
    rst = 1'b1; instr_in = '0; instr_valid_in = 1'b0; wb_en_in = 1'b0;
    wb_rd_in = '0; wb_data_in = '0; ex_ready_in = 1'b0; last_rdy = 1'b0;

    tbl[0] = '{0, 32'h0,         1, 5, 32'h10,        1, 0, 32'h0,         32'h0, 3'd0, 0, 5'd0, 0};
    tbl[1] = '{0, 32'h0,         1, 6, 32'h3,         1, 0, 32'h0,         32'h0, 3'd0, 0, 5'd0, 0};
    tbl[2] = '{1, 32'h406283B3,  0, 0, 32'h0,         1, 1, 32'h10,        32'h3, 3'd0, 1, 5'd7, 0};
    tbl[3] = '{1, 32'h000280B3,  1, 5, 32'hDEADBEEF,  1, 1, 32'hDEADBEEF,  32'h0, 3'd0, 0, 5'd1, 0};
    tbl[4] = '{0, 32'h0,         1, 0, 32'hFFFFFFFF,  1, 0, 32'hDEADBEEF,  32'h0, 3'd0, 0, 5'd1, 0};
    tbl[5] = '{1, 32'h00000133,  0, 0, 32'h0,         1, 1, 32'h0,         32'h0, 3'd0, 0, 5'd2, 0};
    tbl[6] = '{1, 32'h4062F1B3,  0, 0, 32'h0,         1, 0, 32'h0,         32'h0, 3'd0, 0, 5'd2, 1};
    tbl[7] = '{1, 32'h00028213,  0, 0, 32'h0,         1, 0, 32'h0,         32'h0, 3'd0, 0, 5'd2, 1};
    tbl[8] = '{0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         32'h0, 3'd0, 0, 5'd2, 0};
    tbl[9] = '{1, 32'h4062D433,  0, 0, 32'h0,         1, 1, 32'hDEADBEEF,  32'h3, 3'd5, 1, 5'd8, 0};

    cyc(1, 0, 32'h0, 0, 0, 0, 0);
    cyc(1, 0, 32'h0, 0, 0, 0, 0);
    chk("reset_ex_valid", {31'd0, ex_valid_out}, 32'd0);
    chk("reset_rs1", rs1_out, 32'd0);

    for (int i = 0; i < 10; i++) begin
      cyc(0, tbl[i].vld, tbl[i].ins, tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].rdy);
      chk($sformatf("tbl%0d_ev", i),  {31'd0, ex_valid_out}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_ill", i), {31'd0, illegal_out},  {31'd0, tbl[i].ill});
      chk($sformatf("tbl%0d_rs1", i), rs1_out, tbl[i].rs1);
      chk($sformatf("tbl%0d_rs2", i), rs2_out, tbl[i].rs2);
      chk($sformatf("tbl%0d_f3", i),  {29'd0, funct3_out},   {29'd0, tbl[i].f3});
      chk($sformatf("tbl%0d_f7", i),  {31'd0, funct7_r_out}, {31'd0, tbl[i].f7});
      chk($sformatf("tbl%0d_rd", i),  {27'd0, rd_out},       {27'd0, tbl[i].rd});
    end

    // Drain-and-replace, then stall with B waiting while x6 is rewritten underneath A.
    cyc(0, 1, OP_A, 0, 0, 0, 1);
    chk("bp_a_rs1", rs1_out, 32'h3);
    chk("bp_a_rs2", rs2_out, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, OP_B, k == 0, 5'd6, 32'h55, 0);
      chk("bp_hold_ready", {31'd0, last_rdy}, 32'd0);
      chk("bp_hold_rs1", rs1_out, 32'h3);
      chk("bp_hold_rd", {27'd0, rd_out}, 32'd9);
    end
    cyc(0, 1, OP_B, 0, 0, 0, 1);
    chk("bp_b_ready", {31'd0, last_rdy}, 32'd1);
    chk("bp_b_ev", {31'd0, ex_valid_out}, 32'd1);
    chk("bp_b_rs1", rs1_out, 32'h55);
    chk("bp_b_rd", {27'd0, rd_out}, 32'd10);

    // Reset while an illegal op is offered and a valid op is held.
    cyc(1, 1, 32'h4062F1B3, 0, 0, 0, 0);
    chk("rst_mid_ev", {31'd0, ex_valid_out}, 32'd0);
    chk("rst_mid_ill", {31'd0, illegal_out}, 32'd0);
    cyc(0, 0, 32'h0, 0, 0, 0, 1);
    chk("rst_mid_ill_after", {31'd0, illegal_out}, 32'd0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [6:0]  f7;
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[6:0] = 7'h33;
      case ($urandom_range(0, 3))
        0, 1:    f7 = 7'h00;
        2:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      ins[31:25] = f7;
      cyc(0, $urandom_range(0, 3) != 0, ins, $urandom_range(0, 1) == 1,
          5'($urandom), $urandom, $urandom_range(0, 9) < 7);
    end

`ifdef RV_ID_SCOREBOARD_EN
    cyc(1, 0, 32'h0, 0, 0, 0, 1);
    cyc(0, 1, 32'h002081B3, 0, 0, 0, 1);            // ADD x3,x1,x2
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, 32'h00318233, 0, 0, 0, 1);          // ADD x4,x3,x3 waits on x3
      chk("sb_stall_ready", {31'd0, last_rdy}, 32'd0);
    end
    cyc(0, 1, 32'h00318233, 1, 5'd3, 32'h77, 1);
    chk("sb_wb_ready", {31'd0, last_rdy}, 32'd1);
    chk("sb_wb_rs1", rs1_out, 32'h77);
    chk("sb_wb_rs2", rs2_out, 32'h77);
    chk("sb_wb_rd", {27'd0, rd_out}, 32'd4);
    cyc(0, 1, 32'h000202B3, 0, 0, 0, 1);            // ADD x5,x4,x0 waits on x4
    chk("sb_stall2_ready", {31'd0, last_rdy}, 32'd0);
    cyc(1, 1, 32'h000202B3, 0, 0, 0, 1);
    chk("sb_rst_ev", {31'd0, ex_valid_out}, 32'd0);
    cyc(0, 1, 32'h000202B3, 0, 0, 0, 1);
    chk("sb_rst_mask_cleared", {31'd0, last_rdy}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
